// File: rtl/crank_wheel_emulator.sv
// crank_wheel_emulator: synthesises an N-M toothed crank wheel waveform for the VR capture path.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ena             run enable (level); a rising level triggers a config check and start
//   sel             tooth active level: 0 = tooth high, 1 = tooth low
//   period          clocks per tooth slot (P), re-sampled at every slot boundary
//   teeth_total     slots per revolution incl. missing (N), re-sampled at wrap
//   teeth_missing   missing slots at end of revolution (M), re-sampled at wrap
//   vr_sig          emulated sensor signal (tooth_act ^ sel)
//   tooth_num       current slot index 0..N-1
//   rev_pulse       one-cycle strobe on the first cycle of slot 0
//   busy            high while running
//   cfg_err         sticky config error; cleared by rst or an accepted start
//
// Optional feature, macro CRANK_EMU_CAM_EN:
//   cam_tooth       slot index carrying the cam pulse, sampled with N and M
//   cam_sig         high for the whole cam_tooth slot on every other revolution

module crank_wheel_emulator #(
    parameter int unsigned PERIOD_WIDTH = 24,
    parameter int unsigned TOOTH_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    sel,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [TOOTH_WIDTH-1:0]  teeth_total,
    input  logic [TOOTH_WIDTH-1:0]  teeth_missing,
`ifdef CRANK_EMU_CAM_EN
    input  logic [TOOTH_WIDTH-1:0]  cam_tooth,
    output logic                    cam_sig,
`endif
    output logic                    vr_sig,
    output logic [TOOTH_WIDTH-1:0]  tooth_num,
    output logic                    rev_pulse,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StActive   = 2'd1;
    localparam logic [1:0] StInactive = 2'd2;
    localparam logic [1:0] StGap      = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [PERIOD_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
    logic [PERIOD_WIDTH-1:0] p_sh_q, p_sh_d;
    logic [TOOTH_WIDTH-1:0]  n_sh_q, n_sh_d;
    logic [TOOTH_WIDTH-1:0]  m_sh_q, m_sh_d;
    logic [TOOTH_WIDTH-1:0]  tooth_num_q, tooth_num_d;
    logic                    tooth_act_q, tooth_act_d;
    logic                    rev_pulse_q, rev_pulse_d;
    logic                    busy_q, busy_d;
    logic                    cfg_err_q, cfg_err_d;

    logic                    p_ok, nm_ok;
    logic                    slot_end, last_slot;
    logic [PERIOD_WIDTH-1:0] half;
    logic [TOOTH_WIDTH-1:0]  real_teeth, next_tooth;

    assign p_ok       = period >= PERIOD_WIDTH'(2);
    // N >= 3 guarantees N-2 does not underflow when it matters
    assign nm_ok      = (teeth_total >= TOOTH_WIDTH'(3)) &&
                        (teeth_missing <= teeth_total - TOOTH_WIDTH'(2));
    assign half       = p_sh_q >> 1;
    assign slot_end   = slot_cnt_q == p_sh_q;
    assign last_slot  = tooth_num_q == n_sh_q - TOOTH_WIDTH'(1);
    assign real_teeth = n_sh_q - m_sh_q;
    assign next_tooth = tooth_num_q + TOOTH_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        p_sh_d      = p_sh_q;
        n_sh_d      = n_sh_q;
        m_sh_d      = m_sh_q;
        tooth_num_d = tooth_num_q;
        rev_pulse_d = 1'b0;
        cfg_err_d   = cfg_err_q;

        if (!ena) begin
            state_d     = StIdle;
            slot_cnt_d  = '0;
            tooth_num_d = '0;
        end else if (state_q == StIdle) begin
            if (p_ok && nm_ok) begin
                p_sh_d      = period;
                n_sh_d      = teeth_total;
                m_sh_d      = teeth_missing;
                cfg_err_d   = 1'b0;
                state_d     = StActive;
                slot_cnt_d  = PERIOD_WIDTH'(1);
                tooth_num_d = '0;
                rev_pulse_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (slot_end) begin
            slot_cnt_d = PERIOD_WIDTH'(1);
            // a bad value at a boundary is flagged but the old shadow keeps running
            if (p_ok) p_sh_d = period;
            else      cfg_err_d = 1'b1;
            if (last_slot) begin
                tooth_num_d = '0;
                state_d     = StActive;
                rev_pulse_d = 1'b1;
                if (nm_ok) begin
                    n_sh_d = teeth_total;
                    m_sh_d = teeth_missing;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end else begin
                tooth_num_d = next_tooth;
                state_d     = (next_tooth < real_teeth) ? StActive : StGap;
            end
        end else begin
            slot_cnt_d = slot_cnt_q + PERIOD_WIDTH'(1);
            if (state_q == StActive && slot_cnt_q == half) state_d = StInactive;
        end

        tooth_act_d = state_d == StActive;
        busy_d      = state_d != StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            slot_cnt_q  <= '0;
            p_sh_q      <= '0;
            n_sh_q      <= '0;
            m_sh_q      <= '0;
            tooth_num_q <= '0;
            tooth_act_q <= 1'b0;
            rev_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            p_sh_q      <= p_sh_d;
            n_sh_q      <= n_sh_d;
            m_sh_q      <= m_sh_d;
            tooth_num_q <= tooth_num_d;
            tooth_act_q <= tooth_act_d;
            rev_pulse_q <= rev_pulse_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign vr_sig    = tooth_act_q ^ sel;
    assign tooth_num = tooth_num_q;
    assign rev_pulse = rev_pulse_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;

`ifdef CRANK_EMU_CAM_EN
    logic [TOOTH_WIDTH-1:0] cam_sh_q, cam_sh_d;
    logic                   rev_tog_q, rev_tog_d;
    logic                   cam_sig_q, cam_sig_d;

    always_comb begin
        cam_sh_d  = cam_sh_q;
        rev_tog_d = rev_tog_q;
        if (ena && state_q == StIdle && p_ok && nm_ok) begin
            cam_sh_d  = cam_tooth;
            rev_tog_d = 1'b0;
        end else if (ena && state_q != StIdle && slot_end && last_slot) begin
            rev_tog_d = ~rev_tog_q;
            if (nm_ok) cam_sh_d = cam_tooth;
        end
        // one cam pulse per two crank revolutions
        cam_sig_d = busy_d && !rev_tog_d && (tooth_num_d == cam_sh_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cam_sh_q  <= '0;
            rev_tog_q <= 1'b0;
            cam_sig_q <= 1'b0;
        end else begin
            cam_sh_q  <= cam_sh_d;
            rev_tog_q <= rev_tog_d;
            cam_sig_q <= cam_sig_d;
        end
    end

    assign cam_sig = cam_sig_q;
`endif

endmodule

// File: tb/tb_crank_wheel_emulator.sv
// Self-checking bench for crank_wheel_emulator: config-check vector table, hand sequences for
// the multi-cycle corners, then randomized runs against an arithmetic reference model.

module tb_crank_wheel_emulator;

    logic        clk = 1'b0;
    logic        rst, ena, sel;
    logic [23:0] period;
    logic [7:0]  teeth_total, teeth_missing;
    logic        vr_sig, rev_pulse, busy, cfg_err;
    logic [7:0]  tooth_num;
`ifdef CRANK_EMU_CAM_EN
    logic [7:0]  cam_tooth;
    logic        cam_sig;
`endif

    int total = 0;
    int bad   = 0;

    crank_wheel_emulator #(
        .PERIOD_WIDTH(24),
        .TOOTH_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sel          (sel),
        .period       (period),
        .teeth_total  (teeth_total),
        .teeth_missing(teeth_missing),
`ifdef CRANK_EMU_CAM_EN
        .cam_tooth    (cam_tooth),
        .cam_sig      (cam_sig),
`endif
        .vr_sig       (vr_sig),
        .tooth_num    (tooth_num),
        .rev_pulse    (rev_pulse),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: time since start plus the configuration latched at start.
    bit m_run = 0, m_err = 0, model_on = 1;
    int m_t = 0, m_p = 2, m_n = 3, m_m = 0, m_cam = 0;
    logic prev_rev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int slot, k, e_act, e_tooth, e_rev, e_cam;
        slot    = (m_t / m_p) % m_n;
        k       = m_t % m_p;
        e_act   = (m_run && slot < m_n - m_m && k < m_p / 2) ? 1 : 0;
        e_tooth = m_run ? slot : 0;
        e_rev   = (m_run && (m_t % (m_n * m_p)) == 0) ? 1 : 0;
        e_cam   = (m_run && ((m_t / (m_n * m_p)) % 2) == 0 && slot == m_cam) ? 1 : 0;
        chk("model_busy", 32'(busy), 32'(m_run));
        chk("model_cfg_err", 32'(cfg_err), 32'(m_err));
        chk("model_vr_sig", 32'(vr_sig), 32'(e_act) ^ 32'(sel));
        chk("model_tooth_num", 32'(tooth_num), 32'(e_tooth));
        chk("model_rev_pulse", 32'(rev_pulse), 32'(e_rev));
`ifdef CRANK_EMU_CAM_EN
        chk("model_cam_sig", 32'(cam_sig), 32'(e_cam));
`endif
        if (e_cam < 0) $display("unreachable");
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_run = 0;
            m_err = 0;
        end else if (!ena) begin
            m_run = 0;
        end else if (!m_run) begin
            if (period >= 2 && teeth_total >= 3 && int'(teeth_missing) + 2 <= int'(teeth_total)) begin
                m_run = 1;
                m_t   = 0;
                m_err = 0;
                m_p   = int'(period);
                m_n   = int'(teeth_total);
                m_m   = int'(teeth_missing);
`ifdef CRANK_EMU_CAM_EN
                m_cam = int'(cam_tooth);
`endif
            end else begin
                m_err = 1;
            end
        end else begin
            m_t++;
        end
        #1;
        if (model_on) check_model();
        chk("rev_not_consecutive", 32'(rev_pulse & prev_rev), 32'd0);
        prev_rev = rev_pulse;
    endtask

    task automatic start_run(input logic s, input int p, input int n, input int m, input int cam);
        ena = 1'b0;
        step();
        sel           = s;
        period        = 24'(p);
        teeth_total   = 8'(n);
        teeth_missing = 8'(m);
`ifdef CRANK_EMU_CAM_EN
        cam_tooth     = 8'(cam);
`endif
        if (cam < 0) $display("unreachable");
        ena = 1'b1;
        step();
    endtask

    typedef struct {
        logic s;
        int   p;
        int   n;
        int   m;
        logic e_busy;
        logic e_err;
    } cfg_vec_t;

    cfg_vec_t tab[8];

    initial begin
        int vr_cnt, rev_cnt;
        int cam_cnt[5];

        tab[0] = '{1'b0, 1,        6,   2,   1'b0, 1'b1};
        tab[1] = '{1'b1, 10,       4,   3,   1'b0, 1'b1};
        tab[2] = '{1'b0, 10,       4,   2,   1'b1, 1'b0};
        tab[3] = '{1'b1, 0,        6,   0,   1'b0, 1'b1};
        tab[4] = '{1'b1, 2,        3,   1,   1'b1, 1'b0};
        tab[5] = '{1'b0, 10,       2,   0,   1'b0, 1'b1};
        tab[6] = '{1'b0, 2,        3,   0,   1'b1, 1'b0};
        tab[7] = '{1'b1, 16777215, 255, 253, 1'b1, 1'b0};

        rst = 1'b1; ena = 1'b1; sel = 1'b1;
        period = 24'd10; teeth_total = 8'd6; teeth_missing = 8'd2;
`ifdef CRANK_EMU_CAM_EN
        cam_tooth = 8'd1;
`endif
        step();
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);
        chk("reset_tooth_num", 32'(tooth_num), 32'd0);
        chk("reset_rev_pulse", 32'(rev_pulse), 32'd0);
        chk("reset_vr_sig", 32'(vr_sig), 32'd1);
        rst = 1'b0; ena = 1'b0;
        step();

        // Config check table
        for (int i = 0; i < 8; i++) begin
            start_run(tab[i].s, tab[i].p, tab[i].n, tab[i].m, 0);
            chk("tab_busy", 32'(busy), 32'(tab[i].e_busy));
            chk("tab_cfg_err", 32'(cfg_err), 32'(tab[i].e_err));
            chk("tab_vr_sig", 32'(vr_sig), 32'(tab[i].e_busy ^ tab[i].s));
            chk("tab_rev_pulse", 32'(rev_pulse), 32'(tab[i].e_busy));
            ena = 1'b0;
            step();
            chk("tab_idle_busy", 32'(busy), 32'd0);
            chk("tab_sticky_err", 32'(cfg_err), 32'(tab[i].e_err));
        end

        // 6-2 wheel, P=10, sel=0: one full revolution plus two wraps
        start_run(1'b0, 10, 6, 2, 1);
        vr_cnt = 0; rev_cnt = 0;
        for (int t = 0; t <= 120; t++) begin
            if (t > 0) step();
            if (t < 60 && vr_sig) vr_cnt++;
            if (rev_pulse) rev_cnt++;
            if (t == 3)  chk("seq1_t3_vr", 32'(vr_sig), 32'd1);
            if (t == 5)  chk("seq1_t5_vr", 32'(vr_sig), 32'd0);
            if (t == 45) chk("seq1_t45_tooth", 32'(tooth_num), 32'd4);
            if (t == 59) chk("seq1_t59_tooth", 32'(tooth_num), 32'd5);
            if (t == 60) chk("seq1_t60_rev", 32'(rev_pulse), 32'd1);
        end
        chk("seq1_vr_high_cycles", 32'(vr_cnt), 32'd20);
        chk("seq1_rev_count", 32'(rev_cnt), 32'd3);

        // Same config inverted
        start_run(1'b1, 10, 6, 2, 1);
        chk("seq2_t0_vr", 32'(vr_sig), 32'd0);
        chk("seq2_t0_rev", 32'(rev_pulse), 32'd1);

        // P changes from 10 to 4 during slot 1
        model_on = 0;
        start_run(1'b0, 10, 6, 2, 1);
        for (int t = 1; t <= 24; t++) begin
            if (t == 13) period = 24'd4;
            step();
            if (t == 19) chk("pchg_t19_tooth", 32'(tooth_num), 32'd1);
            if (t == 20) chk("pchg_t20_tooth", 32'(tooth_num), 32'd2);
            if (t == 21) chk("pchg_t21_vr", 32'(vr_sig), 32'd1);
            if (t == 22) chk("pchg_t22_vr", 32'(vr_sig), 32'd0);
            if (t == 23) chk("pchg_t23_tooth", 32'(tooth_num), 32'd2);
            if (t == 24) chk("pchg_t24_tooth", 32'(tooth_num), 32'd3);
            if (t == 24) chk("pchg_t24_vr", 32'(vr_sig), 32'd1);
        end
        ena = 1'b0;
        step();
        model_on = 1;

        // Drop ena in the gap of a 60-2 wheel
        start_run(1'b0, 100, 60, 2, 3);
        for (int t = 1; t <= 5850; t++) step();
        chk("gap_tooth", 32'(tooth_num), 32'd58);
        chk("gap_vr", 32'(vr_sig), 32'd0);
        ena = 1'b0;
        step();
        chk("gap_drop_busy", 32'(busy), 32'd0);
        chk("gap_drop_tooth", 32'(tooth_num), 32'd0);
        ena = 1'b1;
        step();
        chk("gap_restart_rev", 32'(rev_pulse), 32'd1);
        chk("gap_restart_vr", 32'(vr_sig), 32'd1);

`ifdef CRANK_EMU_CAM_EN
        start_run(1'b0, 10, 6, 2, 1);
        for (int r = 0; r < 5; r++) cam_cnt[r] = 0;
        for (int t = 0; t < 300; t++) begin
            if (t > 0) step();
            if (cam_sig) cam_cnt[t / 60]++;
            if (t == 9)  chk("cam_t9", 32'(cam_sig), 32'd0);
            if (t == 10) chk("cam_t10", 32'(cam_sig), 32'd1);
            if (t == 20) chk("cam_t20", 32'(cam_sig), 32'd0);
        end
        for (int r = 0; r < 5; r++) chk("cam_rev_cycles", 32'(cam_cnt[r]), (r % 2 == 0) ? 32'd10 : 32'd0);
`else
        cam_cnt[0] = 0;
`endif

        // Randomized runs against the model
        for (int it = 0; it < 40; it++) begin
            int n, len;
            n = int'($urandom_range(0, 10));
            start_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), n,
                      int'($urandom_range(0, n)), int'($urandom_range(0, n)));
            len = int'($urandom_range(1, 200));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) sel = ~sel;
                if ($urandom_range(0, 299) == 0) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crank_wheel_emulator.md
Name: crank_wheel_emulator

Overview:
- Synthesises a crank-trigger tooth waveform (N-M toothed wheel, e.g. 60-2) for the hwag VR capture input.
- Sits alongside hwag; its vr_sig drives vr_in in loop-back/bench builds, or an external VR interface in test rigs.
- Tooth period, wheel geometry and polarity come from host registers.
- Emits tooth index and revolution marker for cross-checking the capture and period-counter path.

Parameters:
- PERIOD_WIDTH, 24, width of tooth period and slot counter (matches hwag period counter).
- TOOTH_WIDTH, 8, width of tooth counts and tooth index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ena  in  1  run enable; level sensitive
- sel  in  1  active level of tooth: 0 = tooth high, 1 = tooth low
- period  in  PERIOD_WIDTH  clocks per tooth slot (P)
- teeth_total  in  TOOTH_WIDTH  slots per revolution including missing (N)
- teeth_missing  in  TOOTH_WIDTH  missing slots at end of revolution (M)
- vr_sig  out  1  emulated sensor signal = tooth_act XOR sel
- tooth_num  out  TOOTH_WIDTH  current slot index, 0..N-1
- rev_pulse  out  1  one-cycle strobe on first active cycle of slot 0
- busy  out  1  high when not IDLE
- cfg_err  out  1  sticky; set on rejected start, cleared by rst or next accepted start

Behaviour:
- Reset (clk edge with rst=1): state IDLE, tooth_act=0 (vr_sig=sel), tooth_num=0, rev_pulse=0, busy=0, cfg_err=0, all counters 0. rst has priority over everything.
- States: IDLE, ACTIVE, INACTIVE, GAP. All outputs registered except the vr_sig XOR.
- Config check (IDLE, ena=1): valid iff P>=2, N>=3, M<=N-2.
  - Invalid: cfg_err=1, stay IDLE.
  - Valid: latch P, N, M into shadows, cfg_err=0. Next cycle: ACTIVE, tooth_act=1, tooth_num=0, rev_pulse=1.
- Slot timing:
  - Each slot lasts exactly P clocks. H = P>>1.
  - Real tooth: ACTIVE for H clocks, then INACTIVE for P-H clocks. Example P=5: 2 active, 3 inactive.
  - Slot counter counts 1..P and reloads at slot end.
- Slot sequencing:
  - Real teeth are indices 0..N-M-1.
  - After the last real tooth, GAP for M slots (M*P clocks, tooth_act=0); tooth_num still advances per slot.
  - M=0 skips GAP.
  - After slot N-1, tooth_num wraps to 0, ACTIVE, rev_pulse=1.
- Shadow update:
  - period is re-sampled at every slot boundary; a new P takes effect from the next slot.
  - N and M are re-sampled only at wrap to slot 0.
  - An invalid N/M/P seen at a boundary sets cfg_err, and the block continues with the old shadows.
- ena deassert (any state): next cycle IDLE, tooth_act=0, tooth_num=0, busy=0. No slot completion.
- ena high while already running: no effect.
- Re-assert ena: a new start and a new config check.
- rev_pulse is never high in two consecutive cycles.
- The slot counter never exceeds P; with P=2 and H=1 the pattern alternates 1 active / 1 inactive.

Optional Feature:
- Macro CRANK_EMU_CAM_EN.
- Defined:
  - Adds input cam_tooth [TOOTH_WIDTH] and output cam_sig.
  - An internal revolution toggle flips on each wrap and resets to 0 at start.
  - cam_sig = 1 for the whole slot cam_tooth in revolutions where toggle=0 (one cam pulse per 720°); otherwise 0.
  - cam_sig is 0 in IDLE and on reset.
  - cam_tooth is sampled with N and M.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- rst, then ena=1, sel=0, P=10, N=6, M=2 -> vr_sig high 5 / low 5 for teeth 0..3, then low 20 clocks; rev_pulse every 60 clocks; tooth_num sequence 0..5.
- sel=1, same config -> vr_sig exactly inverted, rev_pulse timing unchanged.
- Start with P=1, or with N=4, M=3 -> cfg_err=1, busy=0, vr_sig=sel. Then P=10, N=4, M=2 -> cfg_err clears on the start cycle.
- Change P from 10 to 4 mid-slot 1 -> slot 1 lasts 10 clocks, slot 2 lasts 4 clocks (2/2).
- Drop ena during the GAP of a 60-2 wheel, P=100 -> next cycle IDLE, tooth_num=0. Re-raise -> rev_pulse one cycle later, tooth 0 active.
- CRANK_EMU_CAM_EN, N=6, M=2, P=10, cam_tooth=1 -> cam_sig high for clocks 10..19 of revolutions 0, 2, 4; low in revolutions 1, 3.
